// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures the rise-to-rise period of a divided clock (sampled as data in the
// clk domain), declares lock after LOCK_COUNT consecutive periods equal to EXPECT_DIV, and flags
// mismatches and stalls on a sticky err.
// Optional duty-cycle check: define CLK_DIV_MON_DUTY_EN to enable high_time measurement and
// the high-phase check while locked. With it undefined, high_time is tied to 0.
module clk_div_monitor #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned EXPECT_DIV = 5,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic             err_clr,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             err,
    output logic [CNT_W-1:0] high_time
);

    localparam int unsigned MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_V   = CNT_W'(EXPECT_DIV);
    localparam logic [MW-1:0]    LAST_M  = MW'(LOCK_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StMeasure, StLocked} state_t;

    state_t            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic              rise;
    logic [CNT_W-1:0]  cnt_q;
    logic [MW-1:0]     match_q, match_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              valid_q, valid_d;
    logic              mism_q, mism_d;
    logic              err_q, err_d, err_set;
    logic              duty_bad;

    assign rise = s2_q & ~s3_q;

    // Two-flop synchronizer plus edge-detect register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= div_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Period counter: restarts at 1 on a rise so its value on the next rise is the period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (rise) begin
            cnt_q <= CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef CLK_DIV_MON_DUTY_EN
    localparam logic [CNT_W-1:0] HALF_LO = CNT_W'(EXPECT_DIV / 2);
    localparam logic [CNT_W-1:0] HALF_HI = CNT_W'((EXPECT_DIV + 1) / 2);

    logic             fall;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] high_q;

    assign fall = ~s2_q & s3_q;
    // A fall completes the high phase; hcnt_q holds its length at that point.
    assign duty_bad = fall && (hcnt_q != HALF_LO) && (hcnt_q != HALF_HI);

    // High-phase counter and latched high time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            if (rise) begin
                hcnt_q <= CNT_W'(1);
            end else if (s2_q && (hcnt_q != CNT_MAX)) begin
                hcnt_q <= hcnt_q + CNT_W'(1);
            end
            if (fall) begin
                high_q <= hcnt_q;
            end
        end
    end

    assign high_time = high_q;
`else
    assign duty_bad  = 1'b0;
    assign high_time = '0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            match_q  <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            mism_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            mism_q   <= mism_d;
            err_q    <= err_d;
        end
    end

    // Next-state: arm on first rise, count matches while acquiring, drop lock on any error.
    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        period_d = period_q;
        valid_d  = 1'b0;
        mism_d   = 1'b0;
        err_set  = 1'b0;
        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StMeasure;
                end
            end
            StMeasure: begin
                if (rise) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    if (cnt_q == EXP_V) begin
                        if (match_q == LAST_M) begin
                            state_d = StLocked;
                            match_d = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                        mism_d  = 1'b1;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d = StIdle;
                    match_d = '0;
                    err_set = 1'b1;
                end
            end
            StLocked: begin
                if (rise) begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    if (cnt_q != EXP_V) begin
                        state_d = StMeasure;
                        match_d = '0;
                        mism_d  = 1'b1;
                        err_set = 1'b1;
                    end
                end else if (duty_bad) begin
                    state_d = StMeasure;
                    match_d = '0;
                    mism_d  = 1'b1;
                    err_set = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = StIdle;
                    match_d = '0;
                    err_set = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                match_d = '0;
            end
        endcase
        // Set beats clear when both happen in the same cycle.
        err_d = err_set | (err_q & ~err_clr);
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign mismatch     = mism_q;
    assign err          = err_q;
    assign locked       = (state_q == StLocked);

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor. The stimulus is a list of (high, low) segments of div_in
// driven synchronously to clk; a segment-level reference model predicts the output events.
module tb_clk_div_monitor;

    localparam int CW = 8;
    localparam int E  = 5;
    localparam int LC = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          div_in = 1'b0;
    logic          err_clr = 1'b0;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          locked;
    logic          mismatch;
    logic          err;
    logic [CW-1:0] high_time;

    clk_div_monitor #(
        .CNT_W     (CW),
        .EXPECT_DIV(E),
        .LOCK_COUNT(LC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .div_in      (div_in),
        .err_clr     (err_clr),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .mismatch    (mismatch),
        .err         (err),
        .high_time   (high_time)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid;
        int per;
        bit mism;
        bit lock;
        bit er;
        int high;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    bit  stim_div[$];
    bit  stim_clr[$];
    int  total = 0;
    int  bad = 0;

    // Reference model, one step per div_in segment.
    int  m_mode = 0;  // 0 idle, 1 acquiring, 2 locked
    int  m_run = 0;
    int  m_last_len = 0;
    int  m_last_h = 0;
    int  m_period = 0;
    bit  m_err = 1'b0;

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int hi_exp(int h);
`ifdef CLK_DIV_MON_DUTY_EN
        return h;
`else
        return 0;
`endif
    endfunction

    function automatic void push_ev(bit v, int p, bit mm, bit lk, bit er, int hi);
        ev_t e;
        e.valid = v;
        e.per   = p;
        e.mism  = mm;
        e.lock  = lk;
        e.er    = er;
        e.high  = hi;
        exp_q.push_back(e);
    endfunction

    // One div_in period starting with a rise; clr pulses err_clr on the edge that reports this
    // rise and on the following edge.
    task automatic add_period(int h, int l, bit clr);
        int p;
        bit mis;
        bit set;
        for (int i = 0; i < h + l; i++) begin
            stim_div.push_back(i < h);
            stim_clr.push_back(clr && (i == 2 || i == 3));
        end
        if (m_mode == 0) begin
            m_mode = 1;
        end else begin
            p   = m_last_len;
            mis = (p != E);
            set = 1'b0;
            if (m_mode == 2) begin
                if (mis) begin
                    set    = 1'b1;
                    m_mode = 1;
                    m_run  = 0;
                end
            end else if (mis) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == LC) begin
                    m_mode = 2;
                    m_run  = 0;
                end
            end
            if (set) m_err = 1'b1;
            else if (clr) m_err = 1'b0;
            m_period = p;
            push_ev(1'b1, p, mis, m_mode == 2, m_err, hi_exp(m_last_h));
            if (clr) m_err = 1'b0;
        end
`ifdef CLK_DIV_MON_DUTY_EN
        if (m_mode == 2 && h != E / 2 && h != (E + 1) / 2) begin
            m_mode = 1;
            m_run  = 0;
            m_err  = 1'b1;
            push_ev(1'b0, m_period, 1'b1, 1'b0, 1'b1, h);
        end
`endif
        // No rise within 256 cycles of the previous one: counter saturates and the block gives up.
        if (h + l >= 256 && m_mode != 0) begin
            m_mode = 0;
            m_run  = 0;
            m_err  = 1'b1;
        end
        m_last_len = h + l;
        m_last_h   = h;
    endtask

    task automatic good(int n);
        for (int i = 0; i < n; i++) add_period(3, 2, 1'b0);
    endtask

    task automatic play();
        while (stim_div.size() > 0) begin
            @(negedge clk);
            div_in  = stim_div.pop_front();
            err_clr = stim_clr.pop_front();
        end
    endtask

    // Monitor: every reported event is matched against the next prediction.
    always @(posedge clk) begin
        #1;
        if (period_valid || mismatch) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: valid=%0d mismatch=%0d period=%0d at %0t",
                         period_valid, mismatch, period, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("ev_valid", int'(period_valid), int'(mon_e.valid));
                check("ev_period", int'(period), mon_e.per);
                check("ev_mismatch", int'(mismatch), int'(mon_e.mism));
                check("ev_locked", int'(locked), int'(mon_e.lock));
                check("ev_err", int'(err), int'(mon_e.er));
                check("ev_high_time", int'(high_time), mon_e.high);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b0;
        #2;
        check("rst_period", int'(period), 0);
        check("rst_valid", int'(period_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_mismatch", int'(mismatch), 0);
        check("rst_err", int'(err), 0);
        check("rst_high_time", int'(high_time), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Lock acquisition.
        good(5);
        play();
        check("acq_locked", int'(locked), 1);
        check("acq_err", int'(err), 0);
        check("acq_period", int'(period), 5);

        // One long period, then relock with err staying set.
        add_period(3, 3, 1'b0);
        good(5);
        play();
        check("relock_locked", int'(locked), 1);
        check("relock_err", int'(err), 1);

        // Clear coinciding with a set keeps err; the clear alone on the next edge drops it.
        add_period(3, 3, 1'b0);
        add_period(3, 2, 1'b1);
        play();
        check("clr_err", int'(err), 0);
        check("clr_locked", int'(locked), 0);

        // Randomized segments.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) add_period(3, 2, 1'b0);
            else add_period(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 1'b0);
        end
        play();

        // Stall while locked.
        good(6);
        play();
        check("stall_pre_locked", int'(locked), 1);
        add_period(3, 400, 1'b0);
        play();
        check("stall_locked", int'(locked), 0);
        check("stall_err", int'(err), 1);
        check("stall_period", int'(period), 5);

        // Counter boundary: 255 is a measurable period, 256 times out.
        good(6);
        add_period(3, 252, 1'b0);
        good(6);
        add_period(3, 253, 1'b0);
        good(6);
        play();
        check("bound_locked", int'(locked), 1);

        // Narrow high phase while locked.
        add_period(1, 4, 1'b0);
        play();
`ifdef CLK_DIV_MON_DUTY_EN
        check("duty_locked", int'(locked), 0);
        check("duty_err", int'(err), 1);
        check("duty_high_time", int'(high_time), 1);
`else
        check("duty_locked", int'(locked), 1);
        check("duty_high_time", int'(high_time), 0);
`endif
        good(6);
        play();

        // Reset while locked.
        check("prerst_locked", int'(locked), 1);
        check("prerst_pending", exp_q.size(), 0);
        #2 rst = 1'b0;
        #1;
        check("midrst_period", int'(period), 0);
        check("midrst_locked", int'(locked), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_valid", int'(period_valid), 0);
        check("midrst_high_time", int'(high_time), 0);
        m_mode   = 0;
        m_run    = 0;
        m_err    = 1'b0;
        m_period = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        good(7);
        play();
        check("post_locked", int'(locked), 1);
        check("post_err", int'(err), 0);

        repeat (10) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
